// File: rtl/alert_handler_reg_pkg.sv
// Shared constants and types for the alert handler class accumulator.
//   NAlerts, N_LOC_ALERT, N_CLASSES, CLASS_DW, AccuCntDw : default sizing
//   accu_state_e                                        : per-class accumulation FSM states
package alert_handler_reg_pkg;

   localparam int unsigned NAlerts     = 1;
   localparam int unsigned N_LOC_ALERT = 4;
   localparam int unsigned N_CLASSES   = 4;
   localparam int unsigned CLASS_DW    = 2;
   localparam int unsigned AccuCntDw   = 16;

   typedef enum logic [1:0] {
      Idle = 2'b00,
      Accu = 2'b01,
      Trig = 2'b10
   } accu_state_e;

endpackage

// File: rtl/alert_handler_accu.sv
// Single-class accumulation counter with threshold FSM.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   class_en_i     : class enable; when low nothing counts or moves
//   clr_i          : return to Idle with a zero count (beats a same-cycle hit)
//   hit_i          : at least one alert mapped to this class fired
//   thresh_i       : accumulation threshold
//   accu_cnt_o     : saturating hit count
//   accu_trig_o    : one-cycle pulse on the (thresh+1)-th hit
module alert_handler_accu
   import alert_handler_reg_pkg::*;
#(
   parameter int unsigned AccuCntDw = alert_handler_reg_pkg::AccuCntDw
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 class_en_i,
   input  logic                 clr_i,
   input  logic                 hit_i,
   input  logic [AccuCntDw-1:0] thresh_i,
   output logic [AccuCntDw-1:0] accu_cnt_o,
   output logic                 accu_trig_o
);

   accu_state_e          state_d, state_q;
   logic [AccuCntDw-1:0] cnt_d, cnt_q;
   logic                 trig_d, trig_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trig_d  = 1'b0;
      if (clr_i) begin
         state_d = Idle;
         cnt_d   = '0;
      end else if (class_en_i && hit_i) begin
         cnt_d = (cnt_q == {AccuCntDw{1'b1}}) ? cnt_q : cnt_q + AccuCntDw'(1);
         // Threshold compare uses the pre-increment count. In Idle the count
         // is always zero, so this also covers the thresh == 0 shortcut.
         unique case (state_q)
            Idle, Accu: begin
               if (cnt_q >= thresh_i) begin
                  state_d = Trig;
                  trig_d  = 1'b1;
               end else begin
                  state_d = Accu;
               end
            end
            Trig:    state_d = Trig;
            default: state_d = Idle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= Idle;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
      end
   end

   assign accu_cnt_o  = cnt_q;
   assign accu_trig_o = trig_q;

endmodule

// File: rtl/alert_handler_class_accu.sv
// Registered alert classifier with sticky causes and per-class accumulation.
//   clk_i, rst_ni                     : clock, synchronous active-low reset
//   alert_trig_i / loc_alert_trig_i   : alert events (level per cycle)
//   alert_en_i / loc_alert_en_i       : per-alert enables
//   alert_class_i / loc_alert_class_i : packed class index per alert, alert 0 in LSBs
//   cause_clr_i / loc_cause_clr_i     : clear sticky cause bits (a same-cycle set wins)
//   class_en_i, class_clr_i           : per-class enable and counter/FSM clear
//   accu_thresh_i                     : packed per-class thresholds
//   alert_cause_o / loc_alert_cause_o : sticky causes
//   class_trig_o                      : registered qualified class hit
//   accu_cnt_o, accu_trig_o           : per-class count and threshold pulse
module alert_handler_class_accu
   import alert_handler_reg_pkg::*;
#(
   parameter int unsigned NAlerts    = alert_handler_reg_pkg::NAlerts,
   parameter int unsigned NLocAlerts = alert_handler_reg_pkg::N_LOC_ALERT,
   parameter int unsigned NClasses   = alert_handler_reg_pkg::N_CLASSES,
   parameter int unsigned ClassDw    = alert_handler_reg_pkg::CLASS_DW,
   parameter int unsigned AccuCntDw  = alert_handler_reg_pkg::AccuCntDw
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NAlerts-1:0]              alert_trig_i,
   input  logic [NLocAlerts-1:0]           loc_alert_trig_i,
   input  logic [NAlerts-1:0]              alert_en_i,
   input  logic [NLocAlerts-1:0]           loc_alert_en_i,
   input  logic [NAlerts*ClassDw-1:0]      alert_class_i,
   input  logic [NLocAlerts*ClassDw-1:0]   loc_alert_class_i,
   input  logic [NAlerts-1:0]              cause_clr_i,
   input  logic [NLocAlerts-1:0]           loc_cause_clr_i,
   input  logic [NClasses-1:0]             class_en_i,
   input  logic [NClasses-1:0]             class_clr_i,
   input  logic [NClasses*AccuCntDw-1:0]   accu_thresh_i,
   output logic [NAlerts-1:0]              alert_cause_o,
   output logic [NLocAlerts-1:0]           loc_alert_cause_o,
   output logic [NClasses-1:0]             class_trig_o,
   output logic [NClasses*AccuCntDw-1:0]   accu_cnt_o,
   output logic [NClasses-1:0]             accu_trig_o
);

   logic [NAlerts-1:0]    hit;
   logic [NLocAlerts-1:0] loc_hit;
   logic [NClasses-1:0]   c_hit;

   logic [NAlerts-1:0]    cause_d, cause_q;
   logic [NLocAlerts-1:0] loc_cause_d, loc_cause_q;
   logic [NClasses-1:0]   class_trig_d, class_trig_q;

   assign hit     = alert_en_i & alert_trig_i;
   assign loc_hit = loc_alert_en_i & loc_alert_trig_i;

   assign cause_d     = (cause_q & ~cause_clr_i) | hit;
   assign loc_cause_d = (loc_cause_q & ~loc_cause_clr_i) | loc_hit;

   // Indices >= NClasses simply never match, so such alerts hit no class.
   always_comb begin
      c_hit = '0;
      for (int unsigned k = 0; k < NClasses; k++) begin
         for (int unsigned i = 0; i < NAlerts; i++) begin
            if (alert_class_i[i*ClassDw +: ClassDw] == ClassDw'(k)) begin
               c_hit[k] = c_hit[k] | hit[i];
            end
         end
         for (int unsigned i = 0; i < NLocAlerts; i++) begin
            if (loc_alert_class_i[i*ClassDw +: ClassDw] == ClassDw'(k)) begin
               c_hit[k] = c_hit[k] | loc_hit[i];
            end
         end
      end
   end

   assign class_trig_d = c_hit & class_en_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cause_q      <= '0;
         loc_cause_q  <= '0;
         class_trig_q <= '0;
      end else begin
         cause_q      <= cause_d;
         loc_cause_q  <= loc_cause_d;
         class_trig_q <= class_trig_d;
      end
   end

   assign alert_cause_o     = cause_q;
   assign loc_alert_cause_o = loc_cause_q;
   assign class_trig_o      = class_trig_q;

   for (genvar k = 0; k < NClasses; k++) begin : g_class
      alert_handler_accu #(
         .AccuCntDw (AccuCntDw)
      ) u_accu (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .class_en_i  (class_en_i[k]),
         .clr_i       (class_clr_i[k]),
         .hit_i       (c_hit[k]),
         .thresh_i    (accu_thresh_i[k*AccuCntDw +: AccuCntDw]),
         .accu_cnt_o  (accu_cnt_o[k*AccuCntDw +: AccuCntDw]),
         .accu_trig_o (accu_trig_o[k])
      );
   end

endmodule

// File: tb/tb_alert_handler_class_accu.sv
module tb_alert_handler_class_accu;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [0:0]  alert_trig, alert_en, cause_clr;
   logic [3:0]  loc_trig, loc_en, loc_cause_clr;
   logic [1:0]  alert_class;
   logic [7:0]  loc_class;
   logic [3:0]  class_en, class_clr;
   logic [63:0] thresh;
   logic [15:0] thresh4;

   logic [0:0]  cause;
   logic [3:0]  loc_cause, class_trig, atrig;
   logic [63:0] cnt;
   logic [0:0]  cause4;
   logic [3:0]  loc_cause4, class_trig4, atrig4;
   logic [15:0] cnt4;

   int checks   = 0;
   int failures = 0;
   int pulses;

   always #5 clk = ~clk;

   alert_handler_class_accu dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .alert_trig_i      (alert_trig),
      .loc_alert_trig_i  (loc_trig),
      .alert_en_i        (alert_en),
      .loc_alert_en_i    (loc_en),
      .alert_class_i     (alert_class),
      .loc_alert_class_i (loc_class),
      .cause_clr_i       (cause_clr),
      .loc_cause_clr_i   (loc_cause_clr),
      .class_en_i        (class_en),
      .class_clr_i       (class_clr),
      .accu_thresh_i     (thresh),
      .alert_cause_o     (cause),
      .loc_alert_cause_o (loc_cause),
      .class_trig_o      (class_trig),
      .accu_cnt_o        (cnt),
      .accu_trig_o       (atrig)
   );

   alert_handler_class_accu #(
      .AccuCntDw (4)
   ) dut4 (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .alert_trig_i      (alert_trig),
      .loc_alert_trig_i  (loc_trig),
      .alert_en_i        (alert_en),
      .loc_alert_en_i    (loc_en),
      .alert_class_i     (alert_class),
      .loc_alert_class_i (loc_class),
      .cause_clr_i       (cause_clr),
      .loc_cause_clr_i   (loc_cause_clr),
      .class_en_i        (class_en),
      .class_clr_i       (class_clr),
      .accu_thresh_i     (thresh4),
      .alert_cause_o     (cause4),
      .loc_alert_cause_o (loc_cause4),
      .class_trig_o      (class_trig4),
      .accu_cnt_o        (cnt4),
      .accu_trig_o       (atrig4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_ni        = 1'b0;
      alert_trig    = '0;
      alert_en      = '0;
      cause_clr     = '0;
      loc_trig      = '0;
      loc_en        = '0;
      loc_cause_clr = '0;
      alert_class   = '0;
      loc_class     = '0;
      class_en      = '0;
      class_clr     = '0;
      thresh        = '0;
      thresh4       = '0;
      tick();
      tick();
      chk("rst_cause", {63'd0, cause}, 64'd0);
      chk("rst_loc_cause", {60'd0, loc_cause}, 64'd0);
      chk("rst_class_trig", {60'd0, class_trig}, 64'd0);
      chk("rst_cnt", cnt, 64'd0);
      chk("rst_atrig", {60'd0, atrig}, 64'd0);
      rst_ni = 1'b1;
      tick();
      chk("idle_cnt", cnt, 64'd0);
      chk("idle_atrig", {60'd0, atrig}, 64'd0);

      // alert 0 -> class 2; loc0 -> class 1, loc1 -> class 3, loc2/loc3 -> class 0
      alert_en    = 1'b1;
      alert_class = 2'd2;
      loc_en      = 4'hF;
      loc_class   = 8'h0D;
      class_en    = 4'hF;
      thresh      = {16'd100, 16'd3, 16'd0, 16'd100};
      thresh4     = {4'd15, 4'd3, 4'd0, 4'd15};

      // Class 2, threshold 3: pulse on the fourth hit only
      for (int i = 1; i <= 5; i++) begin
         alert_trig = 1'b1;
         tick();
         chk($sformatf("a_cnt2_hit%0d", i), {48'd0, cnt[47:32]}, 64'(i));
         chk($sformatf("a_trig2_hit%0d", i), {63'd0, atrig[2]}, (i == 4) ? 64'd1 : 64'd0);
         chk($sformatf("a_ctrig_hit%0d", i), {60'd0, class_trig}, 64'h4);
         chk($sformatf("a_cause_hit%0d", i), {63'd0, cause}, 64'd1);
         alert_trig = 1'b0;
         tick();
         chk($sformatf("a_trig_gap%0d", i), {60'd0, atrig}, 64'd0);
         chk($sformatf("a_ctrig_gap%0d", i), {60'd0, class_trig}, 64'd0);
      end

      // Cause clear alone, then clear together with a set
      cause_clr = 1'b1;
      tick();
      chk("cause_clr_alone", {63'd0, cause}, 64'd0);
      alert_trig = 1'b1;
      tick();
      chk("cause_set_wins", {63'd0, cause}, 64'd1);
      chk("cause_set_cnt2", {48'd0, cnt[47:32]}, 64'd6);
      cause_clr  = 1'b0;
      alert_trig = 1'b0;
      tick();

      // Class 1, threshold 0: global + local hit in one cycle count once
      alert_class = 2'd1;
      alert_trig  = 1'b1;
      loc_trig    = 4'b0001;
      tick();
      chk("b_cnt1", {48'd0, cnt[31:16]}, 64'd1);
      chk("b_atrig", {60'd0, atrig}, 64'h2);
      chk("b_ctrig", {60'd0, class_trig}, 64'h2);
      chk("b_loc_cause", {60'd0, loc_cause}, 64'h1);
      alert_trig = 1'b0;
      loc_trig   = 4'b0000;
      tick();
      chk("b_ctrig_off", {60'd0, class_trig}, 64'd0);
      chk("b_atrig_off", {60'd0, atrig}, 64'd0);
      chk("b_cnt1_hold", {48'd0, cnt[31:16]}, 64'd1);

      // In Trig: counting continues, no further pulse
      alert_trig = 1'b1;
      tick();
      chk("trig_cnt1", {48'd0, cnt[31:16]}, 64'd2);
      chk("trig_no_pulse", {60'd0, atrig}, 64'd0);
      // Class disabled: no count, no class hit
      class_en = 4'b1101;
      tick();
      chk("dis_cnt1", {48'd0, cnt[31:16]}, 64'd2);
      chk("dis_ctrig", {60'd0, class_trig}, 64'd0);
      chk("dis_atrig", {60'd0, atrig}, 64'd0);
      // Re-enabled: still Trig, no re-pulse
      class_en = 4'hF;
      tick();
      chk("reen_cnt1", {48'd0, cnt[31:16]}, 64'd3);
      chk("reen_atrig", {60'd0, atrig}, 64'd0);
      alert_trig = 1'b0;
      tick();

      // Clear beats a same-cycle hit; hit still shows on class_trig and cause
      class_clr  = 4'b0010;
      alert_trig = 1'b1;
      tick();
      chk("c_cnt1", {48'd0, cnt[31:16]}, 64'd0);
      chk("c_ctrig", {60'd0, class_trig}, 64'h2);
      chk("c_atrig", {60'd0, atrig}, 64'd0);
      chk("c_cause", {63'd0, cause}, 64'd1);
      class_clr  = 4'b0000;
      alert_trig = 1'b0;
      tick();
      // Back in Idle: next hit with threshold 0 pulses again
      alert_trig = 1'b1;
      tick();
      chk("c_idle_cnt1", {48'd0, cnt[31:16]}, 64'd1);
      chk("c_idle_pulse", {60'd0, atrig}, 64'h2);
      alert_trig = 1'b0;
      tick();

      // Disabled alert: no cause, no count
      cause_clr = 1'b1;
      tick();
      chk("d_cause_clr", {63'd0, cause}, 64'd0);
      cause_clr  = 1'b0;
      alert_en   = 1'b0;
      alert_trig = 1'b1;
      tick();
      chk("d_cause", {63'd0, cause}, 64'd0);
      chk("d_ctrig", {60'd0, class_trig}, 64'd0);
      chk("d_cnt1", {48'd0, cnt[31:16]}, 64'd1);
      alert_trig    = 1'b0;
      alert_en      = 1'b1;
      loc_cause_clr = 4'hF;
      tick();
      chk("d_loc_cause_clr", {60'd0, loc_cause}, 64'd0);
      loc_cause_clr = 4'h0;

      // 4-bit counter, threshold 15, 20 back-to-back hits on class 0
      pulses   = 0;
      loc_trig = 4'b0100;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (atrig4[0]) pulses++;
         chk($sformatf("e_cnt0_hit%0d", i), {60'd0, cnt4[3:0]}, (i > 15) ? 64'd15 : 64'(i));
         chk($sformatf("e_trig0_hit%0d", i), {63'd0, atrig4[0]}, (i == 16) ? 64'd1 : 64'd0);
      end
      chk("e_pulse_count", 64'(pulses), 64'd1);

      // Reset mid-accumulation wins over a same-cycle hit
      rst_ni = 1'b0;
      tick();
      chk("r_cnt", cnt, 64'd0);
      chk("r_atrig", {60'd0, atrig}, 64'd0);
      chk("r_ctrig", {60'd0, class_trig}, 64'd0);
      chk("r_loc_cause", {60'd0, loc_cause}, 64'd0);
      rst_ni   = 1'b1;
      loc_trig = 4'b0000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
